traffic_light_ctrl: RTL and testbench

Two-way traffic-light controller for a crossing of street A and street B. Vehicle sensors Sa and Sb request right-of-way. A Moore state machine sequences green, yellow and optional all-red phases with programmable minimum durations, so that at least one street always shows red. The block sits at the top of the intersection-control path and drives the lamp drivers directly.

---
 rtl/tlc_pkg.sv | 47 ++++
 rtl/tlc_phase_timer.sv | 44 ++++
 rtl/traffic_light_ctrl.sv | 162 ++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tlc_pkg
//  Description : Shared types and constants for the two-way traffic-light
//                controller: FSM state encoding, default phase durations,
//                lamp-vector encoding {G,Y,R} and a small sizing helper.
//                The all-red states exist only when TLC_ALL_RED_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package tlc_pkg;

    // Default phase durations, in clock cycles
    localparam int GREEN_MIN_DEF   = 5;
    localparam int YELLOW_CYC_DEF  = 2;
    localparam int ALL_RED_CYC_DEF = 1;

    // Per-street lamp vector, ordered {G,Y,R}
    typedef logic [2:0] lamp_t;

    localparam lamp_t LAMP_G   = 3'b100;
    localparam lamp_t LAMP_Y   = 3'b010;
    localparam lamp_t LAMP_R   = 3'b001;
    localparam lamp_t LAMP_OFF = 3'b000;

    // Controller states; all-red clearance states only in the extended build
    typedef enum logic [2:0] {
        ST_A_GREEN  = 3'd0,
        ST_A_YELLOW = 3'd1,
`ifdef TLC_ALL_RED_EN
        ST_AR_TO_B  = 3'd2,
        ST_AR_TO_A  = 3'd5,
`endif
        ST_B_GREEN  = 3'd3,
        ST_B_YELLOW = 3'd4
    } tlc_state_e;

    // Largest of three durations, used to size the phase counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage : tlc_pkg
`default_nettype wire

// File: rtl/tlc_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tlc_phase_timer
//  Description : Clearable, saturating up-counter that measures time spent in
//                the current phase. o_reached flags that the count has reached
//                the supplied target (duration minus one).
//  Revision    : 1.0 - initial release
// ============================================================================
module tlc_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic [CNT_W-1:0] i_target,
    output logic             o_reached
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear on phase entry, otherwise count up and hold at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_reached = (cnt_q >= i_target);

endmodule : tlc_phase_timer
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_ctrl
//  Description : Two-way traffic-light controller (Moore FSM). Green is held
//                for at least GREEN_MIN cycles and released only when the
//                opposing street requests; yellow lasts exactly YELLOW_CYC.
//                Build option TLC_ALL_RED_EN inserts ALL_RED_CYC cycles of
//                all-red clearance after each yellow.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl
    import tlc_pkg::*;
#(
    parameter int GREEN_MIN   = GREEN_MIN_DEF,
    parameter int YELLOW_CYC  = YELLOW_CYC_DEF,
    parameter int ALL_RED_CYC = ALL_RED_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic Sa,
    input  logic Sb,
    output logic Ga,
    output logic Ya,
    output logic Ra,
    output logic Gb,
    output logic Yb,
    output logic Rb
);

    localparam int CNT_W = $clog2(max3(GREEN_MIN, YELLOW_CYC, ALL_RED_CYC)) + 1;

    // Counter compare targets: a phase of N cycles ends when the count is N-1
    localparam logic [CNT_W-1:0] c_green_tgt   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] c_yellow_tgt  = CNT_W'(YELLOW_CYC - 1);
`ifdef TLC_ALL_RED_EN
    localparam logic [CNT_W-1:0] c_all_red_tgt = CNT_W'(ALL_RED_CYC - 1);
`endif

    tlc_state_e       state_q;
    tlc_state_e       state_d;
    logic [CNT_W-1:0] w_tmr_tgt;
    logic             w_tmr_clr;
    logic             w_tmr_reached;
    lamp_t            w_lamp_a;
    lamp_t            w_lamp_b;

    // Phase counter restarts whenever the state changes
    assign w_tmr_clr = (state_d != state_q);

    tlc_phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk       (clk),
        .rst_n     (reset),
        .i_clr     (w_tmr_clr),
        .i_target  (w_tmr_tgt),
        .o_reached (w_tmr_reached)
    );

    // State register; reset lands in A green
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_A_GREEN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-phase duration select
    always_comb begin
        state_d   = state_q;
        w_tmr_tgt = c_green_tgt;
        case (state_q)
            ST_A_GREEN: begin
                // Only a request from B releases A's green
                w_tmr_tgt = c_green_tgt;
                if (w_tmr_reached && Sb) begin
                    state_d = ST_A_YELLOW;
                end
            end
            ST_A_YELLOW: begin
                w_tmr_tgt = c_yellow_tgt;
                if (w_tmr_reached) begin
`ifdef TLC_ALL_RED_EN
                    state_d = ST_AR_TO_B;
`else
                    state_d = ST_B_GREEN;
`endif
                end
            end
`ifdef TLC_ALL_RED_EN
            ST_AR_TO_B: begin
                w_tmr_tgt = c_all_red_tgt;
                if (w_tmr_reached) begin
                    state_d = ST_B_GREEN;
                end
            end
`endif
            ST_B_GREEN: begin
                // Only a request from A releases B's green
                w_tmr_tgt = c_green_tgt;
                if (w_tmr_reached && Sa) begin
                    state_d = ST_B_YELLOW;
                end
            end
            ST_B_YELLOW: begin
                w_tmr_tgt = c_yellow_tgt;
                if (w_tmr_reached) begin
`ifdef TLC_ALL_RED_EN
                    state_d = ST_AR_TO_A;
`else
                    state_d = ST_A_GREEN;
`endif
                end
            end
`ifdef TLC_ALL_RED_EN
            ST_AR_TO_A: begin
                w_tmr_tgt = c_all_red_tgt;
                if (w_tmr_reached) begin
                    state_d = ST_A_GREEN;
                end
            end
`endif
            default: begin
                state_d = ST_A_GREEN;
            end
        endcase
    end

    // Lamp decode from the state register only; unlisted states show red
    always_comb begin
        w_lamp_a = LAMP_R;
        w_lamp_b = LAMP_R;
        case (state_q)
            ST_A_GREEN: begin
                w_lamp_a = LAMP_G;
                w_lamp_b = LAMP_R;
            end
            ST_A_YELLOW: begin
                w_lamp_a = LAMP_Y;
                w_lamp_b = LAMP_R;
            end
            ST_B_GREEN: begin
                w_lamp_a = LAMP_R;
                w_lamp_b = LAMP_G;
            end
            ST_B_YELLOW: begin
                w_lamp_a = LAMP_R;
                w_lamp_b = LAMP_Y;
            end
            default: begin
                w_lamp_a = LAMP_R | LAMP_OFF;
                w_lamp_b = LAMP_R | LAMP_OFF;
            end
        endcase
    end

    assign {Ga, Ya, Ra} = w_lamp_a;
    assign {Gb, Yb, Rb} = w_lamp_b;

endmodule : traffic_light_ctrl
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_light_ctrl
//  Description : Directed self-checking bench for traffic_light_ctrl with
//                default durations (green 5, yellow 2, all-red 1). Expected
//                lamp patterns come from a phase-position model of the cycle.
//                Honours TLC_ALL_RED_EN for the expected sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_ctrl;

    // Phase codes used by the expectation model
    localparam int PH_AG = 0;
    localparam int PH_AY = 1;
    localparam int PH_BG = 2;
    localparam int PH_BY = 3;
    localparam int PH_AR = 4;

`ifdef TLC_ALL_RED_EN
    localparam int PERIOD  = 16;
    localparam int EARLY_E = 9;
`else
    localparam int PERIOD  = 14;
    localparam int EARLY_E = 8;
`endif

    logic clk;
    logic clk_en;
    logic reset;
    logic Sa;
    logic Sb;
    logic Ga, Ya, Ra, Gb, Yb, Rb;

    int checks;
    int errors;
    int m;

    traffic_light_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .Sa    (Sa),
        .Sb    (Sb),
        .Ga    (Ga),
        .Ya    (Ya),
        .Ra    (Ra),
        .Gb    (Gb),
        .Yb    (Yb),
        .Rb    (Rb)
    );

    // Gateable clock so reset can be exercised with no edges
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Absolute time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Expected {Ga,Ya,Ra,Gb,Yb,Rb} for a phase
    function automatic logic [5:0] lamps(input int ph);
        case (ph)
            PH_AG:   return 6'b100_001;
            PH_AY:   return 6'b010_001;
            PH_BG:   return 6'b001_100;
            PH_BY:   return 6'b001_010;
            default: return 6'b001_001;
        endcase
    endfunction

    // Phase at position n cycles after A-green entry, both streets requesting
    function automatic int phase_of(input int n);
        int k;
        k = n % PERIOD;
`ifdef TLC_ALL_RED_EN
        if (k < 5)       return PH_AG;
        else if (k < 7)  return PH_AY;
        else if (k == 7) return PH_AR;
        else if (k < 13) return PH_BG;
        else if (k < 15) return PH_BY;
        else             return PH_AR;
`else
        if (k < 5)       return PH_AG;
        else if (k < 7)  return PH_AY;
        else if (k < 12) return PH_BG;
        else             return PH_BY;
`endif
    endfunction

    function automatic logic [5:0] obs();
        return {Ga, Ya, Ra, Gb, Yb, Rb};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [5:0] exp_v;
        exp_v = lamps(PH_AG);
        Sa = 1'b0;
        Sb = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #30;
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL reset_async got %b want %b", obs(), exp_v);
        end
        clk_en = 1'b1;
        step();
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL reset_hold got %b want %b", obs(), exp_v);
        end
        reset = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL idle_hold cycle=%0d got %b want %b", i, obs(), exp_v);
            end
        end
    endtask

    task automatic test_early_b();
        logic [5:0] exp_v;
        reset = 1'b0;
        Sa = 1'b0;
        Sb = 1'b1;
        step();
        reset = 1'b1;
        m = 0;
        exp_v = lamps(PH_AG);
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL early_b_start got %b want %b", obs(), exp_v);
        end
        while (m < EARLY_E) begin
            m++;
            step();
            exp_v = lamps(phase_of(m));
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL early_b pos=%0d got %b want %b", m, obs(), exp_v);
            end
        end
    endtask

    task automatic test_handoff_a();
        logic [5:0] exp_v;
        Sa = 1'b1;
        Sb = 1'b0;
        while (m < PERIOD) begin
            m++;
            step();
            exp_v = lamps(phase_of(m));
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL handoff_a pos=%0d got %b want %b", m, obs(), exp_v);
            end
        end
    endtask

    task automatic test_both_high();
        logic [5:0] exp_v;
        Sa = 1'b1;
        Sb = 1'b1;
        m = 0;
        for (int i = 0; i < 60; i++) begin
            m++;
            step();
            exp_v = lamps(phase_of(m));
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL both_high pos=%0d got %b want %b", m, obs(), exp_v);
            end
        end
    endtask

    task automatic test_reset_in_b_yellow();
        logic [5:0] exp_v;
        int guard;
        guard = 0;
        while (phase_of(m) != PH_BY && guard < PERIOD) begin
            guard++;
            m++;
            step();
            exp_v = lamps(phase_of(m));
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL to_b_yellow pos=%0d got %b want %b", m, obs(), exp_v);
            end
        end
        reset = 1'b0;
        #1;
        exp_v = lamps(PH_AG);
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL rst_b_yellow got %b want %b", obs(), exp_v);
        end
        step();
        reset = 1'b1;
        m = 0;
        for (int i = 1; i <= 6; i++) begin
            m++;
            step();
            exp_v = lamps(phase_of(m));
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL after_rst pos=%0d got %b want %b", m, obs(), exp_v);
            end
        end
    endtask

    // Request raised at cycle n of a long A green; a sub-cycle pulse is lost
    task automatic test_late_request(input int n);
        logic [5:0] exp_v;
        reset = 1'b0;
        Sa = 1'b0;
        Sb = 1'b0;
        step();
        reset = 1'b1;
        exp_v = lamps(PH_AG);
        for (int k = 1; k < n; k++) begin
            step();
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL late_hold n=%0d cycle=%0d got %b want %b", n, k, obs(), exp_v);
            end
            if (k == n / 2) begin
                Sb = 1'b1;
                #2;
                Sb = 1'b0;
            end
        end
        Sb = 1'b1;
        exp_v = lamps(PH_AY);
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL late_req n=%0d y=%0d got %b want %b", n, k, obs(), exp_v);
            end
        end
        Sb = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m      = 0;
        clk_en = 1'b0;
        reset  = 1'b1;
        Sa     = 1'b0;
        Sb     = 1'b0;
        test_reset();
        test_early_b();
        test_handoff_a();
        test_both_high();
        test_reset_in_b_yellow();
        test_late_request(20);
        test_late_request(17);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_traffic_light_ctrl
`default_nettype wire
